// File: rtl/serial_slave.sv
// Serial frame slave: receives a 14-bit address (plus 8-bit write data) over a
// 14-cycle strobe, then writes its local byte memory or returns a 9-cycle read response.
module serial_slave #(
    parameter logic [1:0] SLAVE_ID = 2'b10,
    parameter int          MEM_AW   = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic read_en,
    input  logic addr_rx,
    input  logic data_rx,
    output logic data_tx,
    output logic slave_valid,
    output logic slave_ready
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RX_ADDR  = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_READ_MEM = 3'd3;
    localparam logic [2:0] ST_TX       = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rd_q, rd_d;
    logic [7:0]  tx_q, tx_d;
    logic        data_tx_q, data_tx_d;
    logic        slave_valid_q, slave_valid_d;

    logic [7:0]        mem [2**MEM_AW];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [13:0]       addr_shift;

    assign mem_addr   = addr_q[MEM_AW-1:0];
    assign addr_shift = {addr_q[12:0], addr_rx};

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_d          = rd_q;
        tx_d          = tx_q;
        data_tx_d     = data_tx_q;
        slave_valid_d = slave_valid_q;
        mem_we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    addr_d  = addr_shift;
                    data_d  = {data_q[6:0], data_rx};
                    rd_d    = read_en;
                    count_d = 4'd1;
                    state_d = ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: begin
                if (!valid) begin
                    count_d = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + 4'd1;
                    addr_d  = addr_shift;
                    // count_q holds the previous edge index, so 1..7 covers edges e2..e8
                    if (count_q < 4'd8) begin
                        data_d = {data_q[6:0], data_rx};
                    end
                    if (count_q == 4'd13) begin
                        count_d = 4'd0;
                        if (addr_shift[13:12] != SLAVE_ID) begin
                            state_d = ST_IDLE;
                        end else if (rd_q) begin
                            state_d = ST_READ_MEM;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                mem_we  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_READ_MEM: begin
                tx_d          = mem[mem_addr];
                slave_valid_d = 1'b1;
                data_tx_d     = 1'b0;
                count_d       = 4'd0;
                state_d       = ST_TX;
            end
            ST_TX: begin
                if (count_q == 4'd8) begin
                    slave_valid_d = 1'b0;
                    data_tx_d     = 1'b0;
                    count_d       = 4'd0;
                    state_d       = ST_IDLE;
                end else begin
                    data_tx_d = tx_q[7];
                    tx_d      = {tx_q[6:0], 1'b0};
                    count_d   = count_q + 4'd1;
                end
            end
            default: begin
                count_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= 4'd0;
            addr_q        <= 14'd0;
            data_q        <= 8'd0;
            rd_q          <= 1'b0;
            tx_q          <= 8'd0;
            data_tx_q     <= 1'b0;
            slave_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rd_q          <= rd_d;
            tx_q          <= tx_d;
            data_tx_q     <= data_tx_d;
            slave_valid_q <= slave_valid_d;
        end
    end

    // Memory is deliberately not reset; reset clears state_q so mem_we is low while it is held.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= data_q;
        end
    end

    assign data_tx     = data_tx_q;
    assign slave_valid = slave_valid_q;
    assign slave_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_serial_slave.sv
// Randomized scoreboard bench for serial_slave: frames drive a byte-memory model,
// a monitor collects each read response and compares it against the queued expectation.
module tb_serial_slave;

    localparam logic [1:0] ID = 2'b10;

    logic clock = 1'b0;
    logic reset, valid, read_en, addr_rx, data_rx;
    logic data_tx, slave_valid, slave_ready;

    serial_slave #(.SLAVE_ID(ID), .MEM_AW(12)) dut (
        .clock(clock), .reset(reset), .valid(valid), .read_en(read_en),
        .addr_rx(addr_rx), .data_rx(data_rx), .data_tx(data_tx),
        .slave_valid(slave_valid), .slave_ready(slave_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        int         c1;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mm[int];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Response monitor
    int         nb = 0;
    int         rise_cyc = 0;
    logic [8:0] bits = 9'd0;
    always @(negedge clock) begin
        if (reset) begin
            nb = 0;
        end else if (slave_valid) begin
            if (nb == 0) rise_cyc = cyc;
            bits = {bits[7:0], data_tx};
            nb++;
        end else if (nb > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_resp: got response of %0d cycles, required none", nb);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_len", nb, 9);
                check("resp_hdr", bits[8], 1'b0);
                check("resp_data", bits[7:0], e.d);
                check("resp_latency", rise_cyc, e.c1 + 14);
                check("tx_after_resp", data_tx, 1'b0);
            end
            nb = 0;
        end
    end

    task automatic idle_inputs();
        valid   = 1'b0;
        read_en = 1'($urandom);
        addr_rx = 1'($urandom);
        data_rx = 1'($urandom);
    endtask

    // One master frame; nv < 14 drops valid early, kill resets during the 4th response cycle.
    task automatic frame(input bit rd, input logic [13:0] a, input logic [7:0] d,
                         input int nv, input bit kill);
        int c1;
        c1 = 0;
        for (int i = 0; i < nv; i++) begin
            valid   = 1'b1;
            read_en = (i == 0) ? rd : 1'($urandom);
            addr_rx = a[13-i];
            data_rx = (i < 8) ? d[7-i] : 1'($urandom);
            if (i == 0) c1 = cyc + 1;
            @(negedge clock);
            if (i == 0) check("ready_busy", slave_ready, 1'b0);
        end
        idle_inputs();
        if (nv < 14) begin
            @(negedge clock);
        end else if (a[13:12] == ID) begin
            if (!rd) begin
                mm[int'(a[11:0])] = d;
                @(negedge clock);
            end else if (kill) begin
                repeat (4) @(negedge clock);
                #1 reset = 1'b1;
                #1;
                check("rst_valid", slave_valid, 1'b0);
                check("rst_tx", data_tx, 1'b0);
                check("rst_ready", slave_ready, 1'b1);
                @(negedge clock);
                @(negedge clock);
                reset = 1'b0;
            end else begin
                exp_q.push_back('{d: mm[int'(a[11:0])], c1: c1});
                repeat (10) @(negedge clock);
            end
        end
        check("ready_idle", slave_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         kind, k, nv;
        logic [13:0] a;
        logic [1:0]  bad_id;
        reset = 1'b1;
        idle_inputs();
        #2;
        check("reset_valid", slave_valid, 1'b0);
        check("reset_tx", data_tx, 1'b0);
        check("reset_ready", slave_ready, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        frame(1'b0, 14'b10110010110010, 8'b11010101, 14, 1'b0);
        frame(1'b1, 14'b10110010110010, 8'h00, 14, 1'b0);
        frame(1'b0, 14'b01110010110010, 8'h00, 14, 1'b0);
        frame(1'b1, 14'b10110010110010, 8'h00, 14, 1'b0);
        frame(1'b0, 14'b10110010110010, 8'h00, 7, 1'b0);
        frame(1'b1, 14'b10110010110010, 8'h00, 14, 1'b0);
        frame(1'b0, 14'h2001, 8'h3C, 14, 1'b0);
        frame(1'b1, 14'h2001, 8'h00, 14, 1'b0);
        frame(1'b1, 14'b10110010110010, 8'h00, 14, 1'b1);
        repeat (2) @(negedge clock);
        frame(1'b1, 14'h2001, 8'h00, 14, 1'b0);

        for (int n = 0; n < 90; n++) begin
            repeat ($urandom_range(0, 3)) begin
                idle_inputs();
                @(negedge clock);
            end
            kind = $urandom_range(0, 9);
            k    = $urandom_range(0, 15);
            a    = {ID, 12'h100 + 12'(k)};
            if (kind <= 1) begin
                nv = $urandom_range(1, 13);
                frame(1'($urandom), a, 8'($urandom), nv, 1'b0);
            end else if (kind == 2) begin
                bad_id = 2'($urandom_range(0, 2));
                if (bad_id == ID) bad_id = 2'b11;
                frame(1'($urandom), {bad_id, a[11:0]}, 8'($urandom), 14, 1'b0);
            end else if (kind >= 7 && mm.exists(int'(a[11:0]))) begin
                frame(1'b1, a, 8'($urandom), 14, 1'b0);
            end else begin
                frame(1'b0, a, 8'($urandom), 14, 1'b0);
            end
        end

        idle_inputs();
        repeat (20) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_slave.md
SERIAL_SLAVE -- requirements
Module: serial_slave

Interface
REQ-001 Parameter SLAVE_ID, default 2'b10, the slave select value matched against frame address bits [13:12].
REQ-002 Parameter MEM_AW, default 12, the local address width; memory depth is 2**MEM_AW bytes, addressed by frame bits [MEM_AW-1:0].
REQ-003 Port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port valid  input  1  master frame strobe; high for exactly 14 consecutive cycles per request frame.
REQ-006 Port read_en  input  1  transfer type, sampled on the first frame edge only: 1 = read, 0 = write.
REQ-007 Port addr_rx  input  1  serial address from the master, MSB (bit 13) first, one bit per valid cycle.
REQ-008 Port data_rx  input  1  serial write data from the master, MSB first, on the first 8 valid cycles of a frame.
REQ-009 Port data_tx  output  1  serial read data to the master.
REQ-010 Port slave_valid  output  1  read response strobe to the master.
REQ-011 Port slave_ready  output  1  high only while the slave is idle and can accept a frame.

Function
REQ-012 The FSM SHALL have states IDLE, RX_ADDR, WRITE, READ_MEM, TX, with a 4-bit edge counter and 14-bit address / 8-bit data shift registers.
REQ-013 IDLE: valid=1 at an edge -> sample edge e1 (addr bit 13, data bit 7, read_en latched), go to RX_ADDR with count=1; valid=0 -> stay IDLE.
REQ-014 RX_ADDR: each edge with valid=1 shifts in one address bit; edges e2..e8 also shift in data bits 6..0; data_rx is ignored on e9..e14.
REQ-015 After edge e14, the block SHALL decode: bits[13:12] != SLAVE_ID -> IDLE, no memory access, no response.
REQ-016 On an ID match with write -> WRITE; at edge e15 the byte is written to mem[addr[MEM_AW-1:0]], then IDLE.
REQ-017 On an ID match with read -> READ_MEM; at edge e15 mem[addr] is loaded into the TX shift register and the state becomes TX.
REQ-018 TX: slave_valid=1 for exactly 9 cycles (after e15 through after e23); data_tx=0 in the first (header) cycle, then bits 7..0 MSB first after e16..e23.
REQ-019 After edge e24, slave_valid=0, data_tx=0, state=IDLE; the read latency from e1 to the first data bit is 16 edges.
REQ-020 valid=0 during RX_ADDR before e14 -> abort: the block SHALL go to IDLE at that edge, clear the counter, and perform no write and no response.
REQ-021 valid and all serial inputs SHALL be ignored in WRITE, READ_MEM and TX; a frame starting there is not captured.
REQ-022 slave_ready SHALL be 1 only in IDLE; it is 0 from e1 until the transaction returns to IDLE.
REQ-023 A new frame MAY start on the first edge after the return to IDLE (back-to-back frames); the frame is captured normally.
REQ-024 data_tx and slave_valid SHALL be registered outputs with no combinational path from any input.

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, counter=0, shift registers=0, data_tx=0, slave_valid=0, slave_ready=1, regardless of clock.
REQ-026 Reset asserted mid-frame or mid-TX SHALL discard the transaction; a pending write is not committed.
REQ-027 Memory contents SHALL NOT be reset and are undefined until written.
REQ-028 After reset release, the first edge with valid=1 is treated as e1.

Verification
REQ-029 Write: SLAVE_ID=2'b10, read_en=0, addr 14'b10110010110010, data 8'b11010101 -> mem[12'hCB2]=8'hD5 after e15; slave_valid stays 0; slave_ready=1 after e15.
REQ-030 Read-back: read_en=1, same address -> slave_valid high for 9 cycles; data_tx = 0,1,1,0,1,0,1,0,1.
REQ-031 ID mismatch: write to addr 14'b01110010110010 with data 8'h00 -> mem[12'hCB2] stays 8'hD5; no response.
REQ-032 Abort: valid drops after 7 cycles of a write frame -> IDLE at that edge; memory unchanged; the next full frame completes normally.
REQ-033 Reset mid-TX: assert reset during the 4th cycle of slave_valid -> slave_valid=0, data_tx=0, slave_ready=1 immediately, without waiting for a clock edge.
REQ-034 Back-to-back: a write to 12'h001 (8'h3C) followed by a read of 12'h001 starting on the first IDLE edge -> the read returns 8'h3C.
